// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU ops, pipeline control, EX/MEM bundle.
// Mux encodings for RegDst / ALUSrc / PCSrc and the forwarding helper.
package cpu_types_pkg;

   localparam int SHAM_W = 5;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;
   typedef logic [5:0]  opcode_t;

   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;

   typedef enum logic [1:0] {
      PIPE_NORMAL, PIPE_STALL, PIPE_FLUSH
   } pipe_state_t;

   localparam logic [1:0] REGDST_RT   = 2'd0;
   localparam logic [1:0] REGDST_RD   = 2'd1;
   localparam logic [1:0] REGDST_RA   = 2'd2;
   localparam logic [1:0] REGDST_ZERO = 2'd3;

   localparam logic [1:0] ALUSRC_RT    = 2'd0;
   localparam logic [1:0] ALUSRC_IMM   = 2'd1;
   localparam logic [1:0] ALUSRC_SHAMT = 2'd2;
   localparam logic [1:0] ALUSRC_LUI   = 2'd3;

   localparam logic [1:0] PCSRC_SEQ = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_J   = 2'd2;
   localparam logic [1:0] PCSRC_JR  = 2'd3;

   typedef struct packed {
      word_t      pc4;
      word_t      alu_out;
      word_t      store_data;
      regbits_t   wsel;
      logic       reg_write;
      logic       dren;
      logic       dwen;
      logic       datomic;
      logic       halt;
      logic [1:0] mem_to_reg;
      logic       ovf;
   } ex_mem_t;

   // MEM result is younger than WB, so it wins; $zero is never forwarded.
   function automatic word_t fwd_pick(
      input regbits_t r, input word_t raw,
      input logic m_en, input regbits_t m_reg, input word_t m_dat,
      input logic w_en, input regbits_t w_reg, input word_t w_dat
   );
      if (m_en && m_reg == r && r != '0) return m_dat;
      if (w_en && w_reg == r && r != '0) return w_dat;
      return raw;
   endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU: wrapping 32-bit ops, zero flag,
// signed overflow for ADD/SUB.
module alu
   import cpu_types_pkg::*;
(
   input  word_t  a,
   input  word_t  b,
   input  aluop_t op,
   output word_t  result,
   output logic   zero,
   output logic   overflow
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      unique case (op)
         ALU_SLL:  result = a << b[SHAM_W-1:0];
         ALU_SRL:  result = a >> b[SHAM_W-1:0];
         ALU_ADD: begin
            result   = a + b;
            overflow = (a[31] == b[31]) && (result[31] != a[31]);
         end
         ALU_SUB: begin
            result   = a - b;
            overflow = (a[31] != b[31]) && (result[31] != a[31]);
         end
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding, ALU, branch resolution,
// and the EX/MEM latch with stall/flush and sticky halt.
module execute_stage
   import cpu_types_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
)(
   input  logic              CLK,
   input  logic              nRST,
   input  pipe_state_t       em_state,
   input  word_t             e_pc4,
   input  logic [1:0]        e_RegDst,
   input  logic [1:0]        e_ALUSrc,
   input  logic [1:0]        e_PCSrc,
   input  logic [1:0]        e_MemToReg,
   input  logic              e_dREN,
   input  logic              e_dWEN,
   input  logic              e_datomic,
   input  logic              e_RegWrite,
   input  logic              e_halt,
   input  logic              e_check_zero,
   input  logic              e_check_overflow,
   input  aluop_t            e_alu_op,
   input  logic [SHAM_W-1:0] e_shift_amt,
   input  regbits_t          e_rs,
   input  regbits_t          e_rd,
   input  regbits_t          e_rt,
   input  opcode_t           e_op,
   input  word_t             e_rdat1,
   input  word_t             e_rdat2,
   input  word_t             e_sign_ext,
   input  word_t             e_taddr,
   input  logic              mf_en,
   input  regbits_t          mf_reg,
   input  word_t             mf_data,
   input  logic              wf_en,
   input  regbits_t          wf_reg,
   input  word_t             wf_data,
   output logic              ex_redirect,
   output word_t             ex_npc,
   output word_t             m_pc4,
   output word_t             m_alu_out,
   output word_t             m_store_data,
   output regbits_t          m_wsel,
   output logic              m_RegWrite,
   output logic              m_dREN,
   output logic              m_dWEN,
   output logic              m_datomic,
   output logic              m_halt,
   output logic [1:0]        m_MemToReg,
   output logic              m_ovf
);

   word_t    a_fwd, b_fwd, alu_a, alu_b, alu_res, br_target;
   logic     alu_zero, alu_ovf, ovf_kill, taken, halt_sticky;
   regbits_t wsel;
   ex_mem_t  nxt, cur;
   logic     unused_bits;

   generate
      if (FWD_EN) begin : g_fwd
         assign a_fwd = fwd_pick(e_rs, e_rdat1, mf_en, mf_reg,
                                 mf_data, wf_en, wf_reg, wf_data);
         assign b_fwd = fwd_pick(e_rt, e_rdat2, mf_en, mf_reg,
                                 mf_data, wf_en, wf_reg, wf_data);
      end else begin : g_raw
         assign a_fwd = e_rdat1;
         assign b_fwd = e_rdat2;
      end
   endgenerate

   // Shift-by-immediate shifts rt, so rt moves onto port A.
   always_comb begin
      alu_a = a_fwd;
      alu_b = b_fwd;
      unique case (1'b1)
         e_ALUSrc == ALUSRC_RT:  alu_b = b_fwd;
         e_ALUSrc == ALUSRC_IMM: alu_b = e_sign_ext;
         e_ALUSrc == ALUSRC_SHAMT: begin
            alu_a = b_fwd;
            alu_b = {{(32-SHAM_W){1'b0}}, e_shift_amt};
         end
         e_ALUSrc == ALUSRC_LUI: alu_b = {e_sign_ext[15:0], 16'h0};
      endcase
   end

   alu u_alu (
      .a        (alu_a),
      .b        (alu_b),
      .op       (e_alu_op),
      .result   (alu_res),
      .zero     (alu_zero),
      .overflow (alu_ovf)
   );

   assign ovf_kill  = e_check_overflow && alu_ovf;
   assign br_target = e_pc4 + {e_sign_ext[29:0], 2'b00};

   always_comb begin
      wsel = '0;
      unique case (1'b1)
         e_RegDst == REGDST_RT:   wsel = e_rt;
         e_RegDst == REGDST_RD:   wsel = e_rd;
         e_RegDst == REGDST_RA:   wsel = 5'd31;
         e_RegDst == REGDST_ZERO: wsel = '0;
      endcase
   end

   always_comb begin
      taken  = 1'b0;
      ex_npc = br_target;
      unique case (1'b1)
         e_PCSrc == PCSRC_SEQ: taken = 1'b0;
         e_PCSrc == PCSRC_BR:  taken = (alu_zero == e_check_zero);
         e_PCSrc == PCSRC_J: begin
            taken  = 1'b1;
            ex_npc = e_taddr;
         end
         e_PCSrc == PCSRC_JR: begin
            taken  = 1'b1;
            ex_npc = a_fwd;
         end
      endcase
   end

   assign ex_redirect = taken && (em_state == PIPE_NORMAL)
                        && !halt_sticky;

   // Once halted, keep issuing bubbles that carry only the halt flag.
   always_comb begin
      nxt = '0;
      if (halt_sticky) begin
         nxt.halt = 1'b1;
      end else begin
         nxt.pc4        = e_pc4;
         nxt.alu_out    = alu_res;
         nxt.store_data = b_fwd;
         nxt.wsel       = wsel;
         nxt.reg_write  = e_RegWrite && !ovf_kill;
         nxt.dren       = e_dREN;
         nxt.dwen       = e_dWEN;
         nxt.datomic    = e_datomic;
         nxt.halt       = e_halt;
         nxt.mem_to_reg = e_MemToReg;
         nxt.ovf        = ovf_kill;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cur         <= '0;
         halt_sticky <= 1'b0;
      end else begin
         unique case (em_state)
            PIPE_NORMAL: begin
               cur <= nxt;
               if (e_halt) halt_sticky <= 1'b1;
            end
            PIPE_FLUSH: cur <= '0;
            default:    cur <= cur;
         endcase
      end
   end

   assign m_pc4        = cur.pc4;
   assign m_alu_out    = cur.alu_out;
   assign m_store_data = cur.store_data;
   assign m_wsel       = cur.wsel;
   assign m_RegWrite   = cur.reg_write;
   assign m_dREN       = cur.dren;
   assign m_dWEN       = cur.dwen;
   assign m_datomic    = cur.datomic;
   assign m_halt       = cur.halt;
   assign m_MemToReg   = cur.mem_to_reg;
   assign m_ovf        = cur.ovf;

   assign unused_bits = ^{e_op, e_sign_ext[31:30]};

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table plus
// stall/flush/reset and halt sequences.
module tb_execute_stage;
   import cpu_types_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST;
   pipe_state_t       em_state;
   word_t             e_pc4, e_rdat1, e_rdat2, e_sign_ext, e_taddr;
   logic [1:0]        e_RegDst, e_ALUSrc, e_PCSrc, e_MemToReg;
   logic              e_dREN, e_dWEN, e_datomic, e_RegWrite, e_halt;
   logic              e_check_zero, e_check_overflow;
   aluop_t            e_alu_op;
   logic [SHAM_W-1:0] e_shift_amt;
   regbits_t          e_rs, e_rd, e_rt;
   opcode_t           e_op;
   logic              mf_en, wf_en;
   regbits_t          mf_reg, wf_reg;
   word_t             mf_data, wf_data;
   logic              ex_redirect;
   word_t             ex_npc, m_pc4, m_alu_out, m_store_data;
   regbits_t          m_wsel;
   logic              m_RegWrite, m_dREN, m_dWEN, m_datomic, m_halt;
   logic [1:0]        m_MemToReg;
   logic              m_ovf;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   execute_stage #(.FWD_EN(1'b1)) dut (
      .CLK(CLK), .nRST(nRST), .em_state(em_state),
      .e_pc4(e_pc4), .e_RegDst(e_RegDst), .e_ALUSrc(e_ALUSrc),
      .e_PCSrc(e_PCSrc), .e_MemToReg(e_MemToReg),
      .e_dREN(e_dREN), .e_dWEN(e_dWEN), .e_datomic(e_datomic),
      .e_RegWrite(e_RegWrite), .e_halt(e_halt),
      .e_check_zero(e_check_zero),
      .e_check_overflow(e_check_overflow),
      .e_alu_op(e_alu_op), .e_shift_amt(e_shift_amt),
      .e_rs(e_rs), .e_rd(e_rd), .e_rt(e_rt), .e_op(e_op),
      .e_rdat1(e_rdat1), .e_rdat2(e_rdat2),
      .e_sign_ext(e_sign_ext), .e_taddr(e_taddr),
      .mf_en(mf_en), .mf_reg(mf_reg), .mf_data(mf_data),
      .wf_en(wf_en), .wf_reg(wf_reg), .wf_data(wf_data),
      .ex_redirect(ex_redirect), .ex_npc(ex_npc),
      .m_pc4(m_pc4), .m_alu_out(m_alu_out),
      .m_store_data(m_store_data), .m_wsel(m_wsel),
      .m_RegWrite(m_RegWrite), .m_dREN(m_dREN), .m_dWEN(m_dWEN),
      .m_datomic(m_datomic), .m_halt(m_halt),
      .m_MemToReg(m_MemToReg), .m_ovf(m_ovf)
   );

   typedef struct {
      string      name;
      logic [1:0] regdst, alusrc, pcsrc, memtoreg;
      logic       rw, dren, dwen, datomic, cz, co, halt;
      aluop_t     op;
      logic [4:0] shamt, rs, rt, rd;
      word_t      pc4, rdat1, rdat2, sext, taddr;
      logic       mfe, wfe;
      logic [4:0] mfr, wfr;
      word_t      mfd, wfd;
      logic       x_redir, x_rw, x_ovf;
      word_t      x_npc, x_alu, x_store;
      logic [4:0] x_wsel;
   } vec_t;

   vec_t tv[$];
   vec_t v;

   function automatic vec_t base(input string nm);
      vec_t b;
      b.name = nm;
      b.regdst = 2'd1; b.alusrc = 2'd0; b.pcsrc = 2'd0;
      b.memtoreg = 2'd0;
      b.rw = 1'b1; b.dren = 1'b0; b.dwen = 1'b0; b.datomic = 1'b0;
      b.cz = 1'b0; b.co = 1'b0; b.halt = 1'b0;
      b.op = ALU_ADD; b.shamt = '0;
      b.rs = 5'd2; b.rt = 5'd3; b.rd = 5'd4;
      b.pc4 = 32'h4; b.rdat1 = 32'd5; b.rdat2 = 32'd7;
      b.sext = '0; b.taddr = '0;
      b.mfe = 1'b0; b.wfe = 1'b0; b.mfr = '0; b.wfr = '0;
      b.mfd = '0; b.wfd = '0;
      b.x_redir = 1'b0; b.x_rw = 1'b1; b.x_ovf = 1'b0;
      b.x_npc = '0; b.x_alu = 32'd12; b.x_store = 32'd7;
      b.x_wsel = 5'd4;
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t d, input pipe_state_t st);
      em_state = st;
      e_pc4 = d.pc4; e_RegDst = d.regdst; e_ALUSrc = d.alusrc;
      e_PCSrc = d.pcsrc; e_MemToReg = d.memtoreg;
      e_dREN = d.dren; e_dWEN = d.dwen; e_datomic = d.datomic;
      e_RegWrite = d.rw; e_halt = d.halt;
      e_check_zero = d.cz; e_check_overflow = d.co;
      e_alu_op = d.op; e_shift_amt = d.shamt;
      e_rs = d.rs; e_rt = d.rt; e_rd = d.rd; e_op = '0;
      e_rdat1 = d.rdat1; e_rdat2 = d.rdat2;
      e_sign_ext = d.sext; e_taddr = d.taddr;
      mf_en = d.mfe; mf_reg = d.mfr; mf_data = d.mfd;
      wf_en = d.wfe; wf_reg = d.wfr; wf_data = d.wfd;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".pc4"}, m_pc4, 32'h0);
      chk({nm, ".alu"}, m_alu_out, 32'h0);
      chk({nm, ".store"}, m_store_data, 32'h0);
      chk({nm, ".ctl"},
          32'({m_wsel, m_RegWrite, m_dREN, m_dWEN, m_datomic,
               m_halt, m_MemToReg, m_ovf}), 32'h0);
   endtask

   initial begin
      nRST = 1'b0;
      drive(base("idle"), PIPE_NORMAL);

      v = base("add");
      tv.push_back(v);
      v = base("fwd_mem_wins");
      v.mfe = 1; v.mfr = 5'd2; v.mfd = 32'd100;
      v.wfe = 1; v.wfr = 5'd2; v.wfd = 32'd9;
      v.x_alu = 32'd107;
      tv.push_back(v);
      v = base("fwd_r0");
      v.rs = 5'd0; v.mfe = 1; v.mfr = 5'd0; v.mfd = 32'd100;
      tv.push_back(v);
      v = base("fwd_wb_rt");
      v.wfe = 1; v.wfr = 5'd3; v.wfd = 32'd20;
      v.x_alu = 32'd25; v.x_store = 32'd20;
      tv.push_back(v);
      v = base("sub");
      v.op = ALU_SUB; v.regdst = 2'd0;
      v.x_alu = 32'hFFFF_FFFE; v.x_wsel = 5'd3;
      tv.push_back(v);
      v = base("beq_taken");
      v.op = ALU_SUB; v.pcsrc = 2'd1; v.cz = 1; v.regdst = 2'd3;
      v.rw = 0; v.pc4 = 32'h40; v.sext = 32'd3;
      v.rdat1 = 32'd8; v.rdat2 = 32'd8;
      v.x_redir = 1; v.x_npc = 32'h4C; v.x_alu = 0;
      v.x_store = 32'd8; v.x_wsel = 0; v.x_rw = 0;
      tv.push_back(v);
      v.name = "bne_not_taken"; v.cz = 0; v.x_redir = 0;
      tv.push_back(v);
      v.name = "beq_back"; v.cz = 1; v.pc4 = 32'h100;
      v.sext = 32'hFFFF_FFFE; v.x_redir = 1; v.x_npc = 32'hF8;
      tv.push_back(v);
      v = base("jal");
      v.pcsrc = 2'd2; v.regdst = 2'd2; v.taddr = 32'h1234;
      v.rs = 0; v.rt = 0; v.rdat1 = 0; v.rdat2 = 0;
      v.x_redir = 1; v.x_npc = 32'h1234; v.x_alu = 0;
      v.x_store = 0; v.x_wsel = 5'd31;
      tv.push_back(v);
      v = base("jr_fwd");
      v.pcsrc = 2'd3; v.regdst = 2'd3; v.rw = 0;
      v.rs = 5'd5; v.rt = 0; v.rdat1 = 32'h200; v.rdat2 = 0;
      v.mfe = 1; v.mfr = 5'd5; v.mfd = 32'h300;
      v.x_redir = 1; v.x_npc = 32'h300; v.x_alu = 32'h300;
      v.x_store = 0; v.x_wsel = 0; v.x_rw = 0;
      tv.push_back(v);
      v = base("lui");
      v.alusrc = 2'd3; v.op = ALU_OR; v.regdst = 2'd0;
      v.rs = 0; v.rdat1 = 0; v.rt = 5'd7; v.rdat2 = 32'h55;
      v.sext = 32'h0000_ABCD;
      v.x_alu = 32'hABCD_0000; v.x_store = 32'h55; v.x_wsel = 5'd7;
      tv.push_back(v);
      v = base("sll");
      v.alusrc = 2'd2; v.op = ALU_SLL; v.shamt = 5'd4; v.rd = 5'd9;
      v.rs = 0; v.rdat1 = 32'hDEAD; v.rdat2 = 32'h1;
      v.x_alu = 32'h10; v.x_store = 32'h1; v.x_wsel = 5'd9;
      tv.push_back(v);
      v = base("slt");
      v.op = ALU_SLT; v.rdat1 = 32'hFFFF_FFFF; v.rdat2 = 32'd1;
      v.x_alu = 32'd1; v.x_store = 32'd1;
      tv.push_back(v);
      v.name = "sltu"; v.op = ALU_SLTU; v.x_alu = 32'd0;
      v.dwen = 1; v.datomic = 1;
      tv.push_back(v);
      v = base("addi_load");
      v.alusrc = 2'd1; v.co = 1; v.regdst = 2'd0; v.sext = 32'hFFFF_FFFC;
      v.rdat1 = 32'd10; v.dren = 1; v.memtoreg = 2'd1;
      v.x_alu = 32'd6; v.x_wsel = 5'd3;
      tv.push_back(v);
      v = base("add_ovf");
      v.co = 1; v.rdat1 = 32'h7FFF_FFFF; v.rdat2 = 32'd1;
      v.x_alu = 32'h8000_0000; v.x_store = 32'd1;
      v.x_rw = 0; v.x_ovf = 1;
      tv.push_back(v);
      v.name = "addu_wrap"; v.co = 0; v.x_rw = 1; v.x_ovf = 0;
      tv.push_back(v);
      v = base("sub_ovf");
      v.op = ALU_SUB; v.co = 1; v.rdat1 = 32'h8000_0000; v.rdat2 = 32'd1;
      v.x_alu = 32'h7FFF_FFFF; v.x_store = 32'd1; v.x_rw = 0; v.x_ovf = 1;
      tv.push_back(v);
      v = base("nor");
      v.op = ALU_NOR; v.rdat1 = 0; v.rdat2 = 0;
      v.x_alu = 32'hFFFF_FFFF; v.x_store = 0;
      tv.push_back(v);

      repeat (2) @(negedge CLK);
      chk_zero("reset");
      nRST = 1'b1;

      foreach (tv[i]) begin
         drive(tv[i], PIPE_NORMAL);
         #1;
         chk({tv[i].name, ".redirect"}, 32'(ex_redirect),
             32'(tv[i].x_redir));
         if (tv[i].x_redir)
            chk({tv[i].name, ".npc"}, ex_npc, tv[i].x_npc);
         @(negedge CLK);
         chk({tv[i].name, ".alu"}, m_alu_out, tv[i].x_alu);
         chk({tv[i].name, ".wsel"}, 32'(m_wsel), 32'(tv[i].x_wsel));
         chk({tv[i].name, ".rw"}, 32'(m_RegWrite), 32'(tv[i].x_rw));
         chk({tv[i].name, ".ovf"}, 32'(m_ovf), 32'(tv[i].x_ovf));
         chk({tv[i].name, ".store"}, m_store_data, tv[i].x_store);
         chk({tv[i].name, ".pc4"}, m_pc4, tv[i].pc4);
         chk({tv[i].name, ".mem"},
             32'({m_MemToReg, m_dREN, m_dWEN, m_datomic, m_halt}),
             32'({tv[i].memtoreg, tv[i].dren, tv[i].dwen,
                  tv[i].datomic, 1'b0}));
      end

      // stall holds, no redirect under stall/flush, flush bubbles
      drive(tv[0], PIPE_NORMAL);
      @(negedge CLK);
      drive(tv[4], PIPE_STALL);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("stall.alu", m_alu_out, 32'd12);
         chk("stall.wsel", 32'(m_wsel), 32'd4);
         chk("stall.rw", 32'(m_RegWrite), 32'd1);
      end
      drive(tv[5], PIPE_STALL);
      #1 chk("stall.redirect", 32'(ex_redirect), 32'd0);
      drive(tv[5], PIPE_FLUSH);
      #1 chk("flush.redirect", 32'(ex_redirect), 32'd0);
      @(negedge CLK);
      chk_zero("flush");

      // async reset in the middle of a stall
      drive(tv[0], PIPE_NORMAL);
      @(negedge CLK);
      chk("prerst.alu", m_alu_out, 32'd12);
      drive(tv[4], PIPE_STALL);
      @(posedge CLK);
      #2 nRST = 1'b0;
      #1 chk_zero("rst_stall");
      @(negedge CLK);
      nRST = 1'b1;
      drive(tv[4], PIPE_NORMAL);
      @(negedge CLK);
      chk("postrst.alu", m_alu_out, 32'hFFFF_FFFE);

      // sticky halt
      v = tv[0];
      v.halt = 1'b1;
      drive(v, PIPE_NORMAL);
      @(negedge CLK);
      chk("halt.m_halt", 32'(m_halt), 32'd1);
      chk("halt.rw", 32'(m_RegWrite), 32'd1);
      chk("halt.alu", m_alu_out, 32'd12);
      drive(tv[0], PIPE_NORMAL);
      @(negedge CLK);
      chk("halted_add.rw", 32'(m_RegWrite), 32'd0);
      chk("halted_add.m_halt", 32'(m_halt), 32'd1);
      chk("halted_add.alu", m_alu_out, 32'd0);
      drive(tv[9], PIPE_NORMAL);
      #1 chk("halted_jr.redirect", 32'(ex_redirect), 32'd0);
      @(negedge CLK);
      chk("halted_jr.m_halt", 32'(m_halt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
